// File: rtl/udp_tx_sched.sv
// rtl/udp_tx_sched.sv - round-robin transmit scheduler in front of the UDP frame generator
//
// Shares one frame generator between N_REQ requesters. Latches the winner's
// addressing fields, enables the generator for exactly one frame, then holds
// an inter-frame gap. A generator that never signals frame end is recovered
// by a timeout that pulses the generator's active-low reset.

module udp_tx_sched #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  s_rst_i,

  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ*48-1:0]   dst_mac_addr_i,
  input  logic [N_REQ*32-1:0]   src_ipv4_addr_i,
  input  logic [N_REQ*32-1:0]   dst_ipv4_addr_i,
  input  logic [N_REQ*16-1:0]   src_udp_port_i,
  input  logic [N_REQ*16-1:0]   dst_udp_port_i,

  output logic [N_REQ-1:0]      gnt_o,
  output logic [N_REQ-1:0]      done_o,
  output logic [N_REQ-1:0]      err_o,

  output logic                  gen_en_o,
  output logic                  gen_s_rst_n_o,
  output logic [47:0]           gen_dst_mac_addr_o,
  output logic [31:0]           gen_src_ipv4_addr_o,
  output logic [31:0]           gen_dst_ipv4_addr_o,
  output logic [15:0]           gen_src_udp_port_o,
  output logic [15:0]           gen_dst_udp_port_o,
  input  logic                  gen_frame_end_i,

  output logic                  busy_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int LW = $clog2(N_REQ);
  localparam int RW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [RW-1:0] RUN_LAST = RW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [RW-1:0]     run_cnt_q, run_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [N_REQ-1:0]  err_q, err_d;
  logic              gen_en_q, gen_en_d;
  logic              gen_rst_n_q, gen_rst_n_d;
  logic              busy_q, busy_d;

  logic [47:0]       dst_mac_q, dst_mac_d;
  logic [31:0]       src_ip_q, src_ip_d;
  logic [31:0]       dst_ip_q, dst_ip_d;
  logic [15:0]       src_port_q, src_port_d;
  logic [15:0]       dst_port_q, dst_port_d;

  // Arbiter outputs
  logic              arb_found;
  logic [LW-1:0]     arb_win;
  int                arb_idx;

  // Fields of the arbitration winner, selected with constant slice offsets
  logic [47:0]       win_dst_mac;
  logic [31:0]       win_src_ip;
  logic [31:0]       win_dst_ip;
  logic [15:0]       win_src_port;
  logic [15:0]       win_dst_port;

  // Round-robin search starting one past the last winner, wrapping at N_REQ
  always_comb begin
    arb_found = 1'b0;
    arb_win   = last_q;
    arb_idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      arb_idx = int'(last_q) + i;
      if (arb_idx >= N_REQ) begin
        arb_idx = arb_idx - N_REQ;
      end
      if (!arb_found && req_i[LW'(arb_idx)]) begin
        arb_found = 1'b1;
        arb_win   = LW'(arb_idx);
      end
    end
  end

  // Field multiplexer for the requester the arbiter picked
  always_comb begin
    win_dst_mac  = '0;
    win_src_ip   = '0;
    win_dst_ip   = '0;
    win_src_port = '0;
    win_dst_port = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_win == LW'(k)) begin
        win_dst_mac  = dst_mac_addr_i[k*48 +: 48];
        win_src_ip   = src_ipv4_addr_i[k*32 +: 32];
        win_dst_ip   = dst_ipv4_addr_i[k*32 +: 32];
        win_src_port = src_udp_port_i[k*16 +: 16];
        win_dst_port = dst_udp_port_i[k*16 +: 16];
      end
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    run_cnt_d   = run_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    err_d       = '0;
    gen_en_d    = gen_en_q;
    gen_rst_n_d = 1'b1;
    dst_mac_d   = dst_mac_q;
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    src_port_d  = src_port_q;
    dst_port_d  = dst_port_q;

    case (state_q)
      ST_IDLE: begin
        gnt_d    = '0;
        gen_en_d = 1'b0;
        if (arb_found) begin
          state_d        = ST_RUN;
          last_d         = arb_win;
          run_cnt_d      = '0;
          gnt_d[arb_win] = 1'b1;
          gen_en_d       = 1'b1;
          dst_mac_d      = win_dst_mac;
          src_ip_d       = win_src_ip;
          dst_ip_d       = win_dst_ip;
          src_port_d     = win_src_port;
          dst_port_d     = win_dst_port;
        end
      end

      ST_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        // Frame end wins over a coincident timeout expiry
        if (gen_frame_end_i) begin
          state_d     = ST_GAP;
          gap_cnt_d   = '0;
          done_d      = gnt_q;
          gnt_d       = '0;
          gen_en_d    = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end else if (run_cnt_q == RUN_LAST) begin
          state_d     = ST_GAP;
          gap_cnt_d   = '0;
          err_d       = gnt_q;
          gnt_d       = '0;
          gen_en_d    = 1'b0;
          gen_rst_n_d = 1'b0;
        end
      end

      ST_GAP: begin
        gnt_d    = '0;
        gen_en_d = 1'b0;
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        gen_en_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output update; reset parks the arbiter so requester 0 wins first
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_RST;
      run_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= '0;
      gen_en_q    <= 1'b0;
      gen_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      dst_mac_q   <= '0;
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      src_port_q  <= '0;
      dst_port_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      run_cnt_q   <= run_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      gen_en_q    <= gen_en_d;
      gen_rst_n_q <= gen_rst_n_d;
      busy_q      <= busy_d;
      dst_mac_q   <= dst_mac_d;
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      src_port_q  <= src_port_d;
      dst_port_q  <= dst_port_d;
    end
  end

  assign gnt_o               = gnt_q;
  assign done_o              = done_q;
  assign err_o               = err_q;
  assign gen_en_o            = gen_en_q;
  assign gen_s_rst_n_o       = gen_rst_n_q;
  assign busy_o              = busy_q;
  assign frame_cnt_o         = frame_cnt_q;
  assign gen_dst_mac_addr_o  = dst_mac_q;
  assign gen_src_ipv4_addr_o = src_ip_q;
  assign gen_dst_ipv4_addr_o = dst_ip_q;
  assign gen_src_udp_port_o  = src_port_q;
  assign gen_dst_udp_port_o  = dst_port_q;

endmodule

// File: tb/tb_udp_tx_sched.sv
// tb/tb_udp_tx_sched.sv - directed self-checking bench for udp_tx_sched

module tb_udp_tx_sched;

  localparam int N   = 4;
  localparam int GAP = 12;
  localparam int TO  = 256;

  logic              clk = 1'b0;
  logic              s_rst_i;
  logic [N-1:0]      req_i;
  logic [N*48-1:0]   dst_mac_addr_i;
  logic [N*32-1:0]   src_ipv4_addr_i;
  logic [N*32-1:0]   dst_ipv4_addr_i;
  logic [N*16-1:0]   src_udp_port_i;
  logic [N*16-1:0]   dst_udp_port_i;
  logic [N-1:0]      gnt_o;
  logic [N-1:0]      done_o;
  logic [N-1:0]      err_o;
  logic              gen_en_o;
  logic              gen_s_rst_n_o;
  logic [47:0]       gen_dst_mac_addr_o;
  logic [31:0]       gen_src_ipv4_addr_o;
  logic [31:0]       gen_dst_ipv4_addr_o;
  logic [15:0]       gen_src_udp_port_o;
  logic [15:0]       gen_dst_udp_port_o;
  logic              gen_frame_end_i;
  logic              busy_o;
  logic [15:0]       frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int salt     = 0;

  udp_tx_sched #(
    .N_REQ          (N),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i               (clk),
    .s_rst_i             (s_rst_i),
    .req_i               (req_i),
    .dst_mac_addr_i      (dst_mac_addr_i),
    .src_ipv4_addr_i     (src_ipv4_addr_i),
    .dst_ipv4_addr_i     (dst_ipv4_addr_i),
    .src_udp_port_i      (src_udp_port_i),
    .dst_udp_port_i      (dst_udp_port_i),
    .gnt_o               (gnt_o),
    .done_o              (done_o),
    .err_o               (err_o),
    .gen_en_o            (gen_en_o),
    .gen_s_rst_n_o       (gen_s_rst_n_o),
    .gen_dst_mac_addr_o  (gen_dst_mac_addr_o),
    .gen_src_ipv4_addr_o (gen_src_ipv4_addr_o),
    .gen_dst_ipv4_addr_o (gen_dst_ipv4_addr_o),
    .gen_src_udp_port_o  (gen_src_udp_port_o),
    .gen_dst_udp_port_o  (gen_dst_udp_port_o),
    .gen_frame_end_i     (gen_frame_end_i),
    .busy_o              (busy_o),
    .frame_cnt_o         (frame_cnt_o)
  );

  always #5 clk = ~clk;

  // Edge counter used to measure latencies
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] f_mac(input int k, input int s);
    return {16'hAC00 + 16'(k), 16'(s), 16'h5A00 + 16'(k)};
  endfunction
  function automatic logic [31:0] f_sip(input int k, input int s);
    return {8'd10, 8'(s), 8'd0, 8'(k + 1)};
  endfunction
  function automatic logic [31:0] f_dip(input int k, input int s);
    return {8'd192, 8'd168, 8'(s), 8'(k + 100)};
  endfunction
  function automatic logic [15:0] f_sport(input int k, input int s);
    return 16'h1000 + 16'(s * 256) + 16'(k);
  endfunction
  function automatic logic [15:0] f_dport(input int k, input int s);
    return 16'h2000 + 16'(s * 16) + 16'(k);
  endfunction

  task automatic set_fields(input int s);
    for (int k = 0; k < N; k++) begin
      dst_mac_addr_i[k*48 +: 48]  = f_mac(k, s);
      src_ipv4_addr_i[k*32 +: 32] = f_sip(k, s);
      dst_ipv4_addr_i[k*32 +: 32] = f_dip(k, s);
      src_udp_port_i[k*16 +: 16]  = f_sport(k, s);
      dst_udp_port_i[k*16 +: 16]  = f_dport(k, s);
    end
  endtask

  task automatic do_reset();
    s_rst_i = 1'b1;
    repeat (3) step();
    check("rst_gnt",     64'(gnt_o), 64'd0);
    check("rst_done",    64'(done_o), 64'd0);
    check("rst_err",     64'(err_o), 64'd0);
    check("rst_en",      64'(gen_en_o), 64'd0);
    check("rst_gen_rst", 64'(gen_s_rst_n_o), 64'd0);
    check("rst_busy",    64'(busy_o), 64'd0);
    check("rst_cnt",     64'(frame_cnt_o), 64'd0);
    check("rst_mac",     64'(gen_dst_mac_addr_o), 64'd0);
    check("rst_dport",   64'(gen_dst_udp_port_o), 64'd0);
    s_rst_i = 1'b0;
    step();
    check("rel_gen_rst", 64'(gen_s_rst_n_o), 64'd1);
  endtask

  // Acts as the generator for one frame: waits for enable, checks grant and
  // fields, raises frame end len cycles into the frame, checks the release.
  task automatic serve(input int exp_k, input int len, input bit drop,
                       input int exp_cnt, output int en_cyc, output int done_cyc);
    logic [N-1:0] exp_g;
    logic [47:0]  e_mac;
    logic [15:0]  e_dport;
    exp_g = '0;
    exp_g[exp_k] = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (gen_en_o) break;
      step();
    end
    check("en_wait", 64'(gen_en_o), 64'd1);
    en_cyc  = cyc;
    e_mac   = f_mac(exp_k, salt);
    e_dport = f_dport(exp_k, salt);
    check("gnt",   64'(gnt_o), 64'(exp_g));
    check("mac",   64'(gen_dst_mac_addr_o), 64'(e_mac));
    check("sip",   64'(gen_src_ipv4_addr_o), 64'(f_sip(exp_k, salt)));
    check("dip",   64'(gen_dst_ipv4_addr_o), 64'(f_dip(exp_k, salt)));
    check("sport", 64'(gen_src_udp_port_o), 64'(f_sport(exp_k, salt)));
    check("dport", 64'(gen_dst_udp_port_o), 64'(e_dport));
    if (drop) begin
      req_i = '0;
      salt++;
      set_fields(salt);
    end
    repeat (len - 1) step();
    check("en_hold", 64'(gen_en_o), 64'd1);
    gen_frame_end_i = 1'b1;
    step();
    gen_frame_end_i = 1'b0;
    done_cyc = cyc;
    check("done",       64'(done_o), 64'(exp_g));
    check("no_err",     64'(err_o), 64'd0);
    check("en_off",     64'(gen_en_o), 64'd0);
    check("gnt_off",    64'(gnt_o), 64'd0);
    check("frame_cnt",  64'(frame_cnt_o), 64'(exp_cnt));
    check("busy_gap",   64'(busy_o), 64'd1);
    check("gen_rst_hi", 64'(gen_s_rst_n_o), 64'd1);
    check("mac_frozen", 64'(gen_dst_mac_addr_o), 64'(e_mac));
    check("dport_frozen", 64'(gen_dst_udp_port_o), 64'(e_dport));
    step();
    check("done_pulse", 64'(done_o), 64'd0);
  endtask

  int e1, d1, e2, d2, rc, t0;
  int lens[5] = '{3, 5, 1, 7, 2};
  bit seen_done;

  initial begin
    s_rst_i         = 1'b1;
    req_i           = '0;
    gen_frame_end_i = 1'b0;
    salt            = 1;
    set_fields(salt);

    // Reset state
    do_reset();

    // Single request, then back-to-back under continuous request
    req_i = 4'b0100;
    rc = cyc;
    serve(2, 10, 1'b0, 1, e1, d1);
    check("req_to_en", 64'(e1 - rc), 64'd1);
    serve(2, 10, 1'b0, 2, e2, d2);
    check("gap_to_en", 64'(e2 - d1), 64'(GAP + 1));
    req_i = '0;

    // Round-robin with all requesters active
    do_reset();
    salt = 2;
    set_fields(salt);
    req_i = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      serve(j % N, lens[j], 1'b0, j + 1, e1, d1);
    end
    req_i = '0;

    // Timeout: generator never signals frame end
    do_reset();
    req_i = 4'b0001;
    for (int i = 0; i < 50; i++) begin
      if (gen_en_o) break;
      step();
    end
    check("to_en_wait", 64'(gen_en_o), 64'd1);
    t0 = cyc;
    for (int i = 0; i < 300; i++) begin
      step();
      if (done_o != '0 || err_o != '0) break;
    end
    check("to_err",     64'(err_o), 64'd1);
    check("to_latency", 64'(cyc - t0), 64'(TO));
    check("to_gen_rst", 64'(gen_s_rst_n_o), 64'd0);
    check("to_done",    64'(done_o), 64'd0);
    check("to_en_off",  64'(gen_en_o), 64'd0);
    check("to_cnt",     64'(frame_cnt_o), 64'd0);
    step();
    check("to_rst_pulse", 64'(gen_s_rst_n_o), 64'd1);
    check("to_err_pulse", 64'(err_o), 64'd0);
    serve(0, 4, 1'b0, 1, e1, d1);
    req_i = '0;

    // Frame end coincident with timeout expiry, then request dropped mid-frame
    do_reset();
    req_i = 4'b0001;
    serve(0, TO, 1'b0, 1, e1, d1);
    req_i = 4'b0010;
    serve(1, 6, 1'b1, 2, e1, d1);

    // Frame end outside RUN is ignored
    seen_done = 1'b0;
    gen_frame_end_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done_o != '0) seen_done = 1'b1;
    end
    gen_frame_end_i = 1'b0;
    check("idle_fe_done", 64'(seen_done), 64'd0);
    check("idle_fe_cnt",  64'(frame_cnt_o), 64'd2);
    check("idle_fe_busy", 64'(busy_o), 64'd0);

    // Mid-frame reset: last winner was 1, so requester 2 is granted next
    req_i = 4'b1111;
    for (int i = 0; i < 50; i++) begin
      if (gen_en_o) break;
      step();
    end
    check("mr_gnt", 64'(gnt_o), 64'b0100);
    repeat (3) step();
    s_rst_i = 1'b1;
    step();
    check("mr_en",      64'(gen_en_o), 64'd0);
    check("mr_gnt_off", 64'(gnt_o), 64'd0);
    check("mr_gen_rst", 64'(gen_s_rst_n_o), 64'd0);
    check("mr_busy",    64'(busy_o), 64'd0);
    check("mr_cnt",     64'(frame_cnt_o), 64'd0);
    s_rst_i = 1'b0;
    serve(0, 3, 1'b0, 1, e1, d1);
    req_i = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
